sdram_req_gen: RTL and testbench
================================

# sdram_req_gen

Request generator sitting directly upstream of the SDRAM state-machine controller. It watches the write-FIFO and read-FIFO fill levels and raises single-burst write or read requests with matching burst lengths. It tracks independent write and read SDRAM addresses that wrap inside programmable windows. Its request, burst and address outputs drive the controller's `sdram_wr_req`/`sdram_rd_req`/burst inputs and the command block's address inputs. The controller's ack outputs come back to this block.

## Interface
Clock and reset: one clock; reset is asynchronous and active-high.

Parameters:
- `ADDR_W`, 24, SDRAM linear address width ({bank, row, col}).
- `BURST_W`, 10, burst-length width.
- `LVL_W`, 11, FIFO level width.
- `RD_FIFO_DEPTH`, 1024, read-FIFO capacity in words.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  async reset, active-high
- `sdram_init_done`  in  1  controller initialisation complete
- `wr_fifo_level`  in  LVL_W  words waiting in write FIFO
- `rd_fifo_level`  in  LVL_W  words held in read FIFO
- `wr_min_addr` / `wr_max_addr`  in  ADDR_W  write window, inclusive
- `rd_min_addr` / `rd_max_addr`  in  ADDR_W  read window, inclusive
- `wr_burst_len` / `rd_burst_len`  in  BURST_W  burst sizes, 1..512
- `wr_load` / `rd_load`  in  1  one-cycle pulse: restart that address at its min
- `read_valid`  in  1  read traffic enabled
- `sdram_wr_ack` / `sdram_rd_ack`  in  1  controller data-phase acks
- `sdram_wr_req` / `sdram_rd_req`  out  1  burst requests
- `sdram_wr_addr` / `sdram_rd_addr`  out  ADDR_W  current burst start address
- `sdram_wr_burst` / `sdram_rd_burst`  out  BURST_W  registered burst lengths
- `busy`  out  1  transaction in flight (state ≠ IDLE)

## Operation
FSM states: IDLE, WR_REQ, WR_RUN, RD_REQ, RD_RUN.

**IDLE**
- No action while `sdram_init_done`=0.
- Apply any pending load first: addr ← min, clear pending. Nothing else is decided that cycle.
- Otherwise, if `wr_fifo_level ≥ wr_burst_len`, latch `sdram_wr_burst` and go to WR_REQ.
- Else if `read_valid` and `rd_fifo_level + rd_burst_len ≤ RD_FIFO_DEPTH`, latch `sdram_rd_burst` and go to RD_REQ.
- Write has priority over read.

**WR_REQ / RD_REQ**
- Hold the request high until the first cycle the matching ack is 1.
- Then drop the request and enter *_RUN.
- Waiting is unbounded (the controller may be refreshing).

**WR_RUN / RD_RUN**
- Wait for the falling edge of the ack: registered ack = 1, current ack = 0.
- Then advance the address and return to IDLE.

**Address advance** (computed at ADDR_W+1 bits, no overflow):
- next = addr + burst.
- If next + burst − 1 > max, next = min (the burst must fit wholly in the window).

**Loads and reset**
- `wr_load`/`rd_load` set a pending flag in any state. The flag is consumed only in IDLE, so an in-flight burst is never disturbed.
- A load arriving in the same cycle as an advance still wins on the next IDLE.
- Reset sets both pending flags, so the first IDLE after `sdram_init_done` loads the min addresses.

**Reset values**
- Requests 0, addresses 0, bursts 0, `busy` 0, state IDLE.
- Pending flags = 1, registered acks 0.
- Reset mid-transaction drops any request immediately (async).

## Timing
- IDLE decision → request high on the next clock edge (registered).
- Request falls on the clock edge after ack is first sampled high. The controller accepts requests only in its idle state, so it never sees a second request for the same burst.
- Ack falling edge detected one cycle after ack drops. The address updates on that edge and the state reaches IDLE in the same cycle.
- At least one IDLE cycle separates consecutive bursts; a pending load adds one more.
- Burst and address outputs are stable from request assertion until the return to IDLE.

## Structure
- Shared package/header holds:
  - state encodings `R_IDLE`, `R_WR_REQ`, `R_WR_RUN`, `R_RD_REQ`, `R_RD_RUN`;
  - default `ADDR_W`/`BURST_W` constants, shared with the controller header.
- One natural sub-module, `addr_wrap_ctr`, instantiated twice (write and read). It contains:
  - the address register;
  - the pending-load flag;
  - the wrap logic, with ports load, advance, min, max, burst, addr.
- The FSM and ack edge detectors live in the top level.

## Test plan
- **Init gating:** `sdram_init_done`=0, `wr_fifo_level`=600, burst 256 → no request. Raise init → IDLE load cycle, then `sdram_wr_req` high with addr = `wr_min_addr`.
- **Write burst:** min 0, max 0xFFFFFF, burst 256. Ack high 256 cycles then low → `sdram_wr_req` drops on the first ack cycle; `sdram_wr_addr` = 256 one cycle after ack falls; `busy` low.
- **Wrap:** window 0..1023, burst 256, four bursts → addresses 0, 256, 512, 768, then 0. Window 0..1000 → 0, 256, 512, 0 (768 would overrun).
- **Priority/read:** both write and read eligible → write first. With `rd_fifo_level`=800, depth 1024, burst 256 → no read. At 768 → read issued.
- **Load mid-burst:** `rd_load` pulse during RD_RUN → burst completes unchanged; next IDLE sets `sdram_rd_addr` = `rd_min_addr`, not the advanced value.
- **Reset mid-request:** `rst` during WR_REQ → `sdram_wr_req` drops asynchronously, outputs at reset values. After release and init, addresses restart at their mins.

Source files
------------

// File: rtl/sdram_req_gen_pkg.sv
// Shared encodings and default widths for the SDRAM request generator and its controller.
package sdram_req_gen_pkg;

    localparam int unsigned SDRAM_ADDR_W  = 24;
    localparam int unsigned SDRAM_BURST_W = 10;

    typedef logic [2:0] req_state_t;

    localparam req_state_t R_IDLE   = 3'd0;
    localparam req_state_t R_WR_REQ = 3'd1;
    localparam req_state_t R_WR_RUN = 3'd2;
    localparam req_state_t R_RD_REQ = 3'd3;
    localparam req_state_t R_RD_RUN = 3'd4;

endpackage

// File: rtl/sdram_req_gen_addr_wrap_ctr.sv
// Burst start-address register that wraps inside an inclusive [min, max] window,
// with a sticky restart request that is only honoured when the owner says so.
module addr_wrap_ctr #(
    parameter int unsigned ADDR_W  = 24,
    parameter int unsigned BURST_W = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               apply_load,
    input  logic               advance,
    input  logic [ADDR_W-1:0]  min_addr,
    input  logic [ADDR_W-1:0]  max_addr,
    input  logic [BURST_W-1:0] burst,
    output logic [ADDR_W-1:0]  addr,
    output logic               pending
);

    localparam int unsigned EW = ADDR_W + 1;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              pending_q, pending_d;
    logic [EW-1:0]     next_raw;
    logic [EW-1:0]     burst_end;
    logic              wrap;

    // The whole next burst must fit below max, otherwise restart at min.
    always_comb begin
        next_raw  = {1'b0, addr_q} + EW'(burst);
        burst_end = next_raw + EW'(burst) - EW'(1);
        wrap      = burst_end > {1'b0, max_addr};
    end

    always_comb begin
        addr_d = addr_q;
        if (apply_load) begin
            addr_d = min_addr;
        end else if (advance) begin
            addr_d = wrap ? min_addr : next_raw[ADDR_W-1:0];
        end
    end

    // A fresh load pulse outranks consumption so a coincident request is not lost.
    always_comb begin
        pending_d = pending_q;
        if (load) begin
            pending_d = 1'b1;
        end else if (apply_load) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q    <= '0;
            pending_q <= 1'b1;
        end else begin
            addr_q    <= addr_d;
            pending_q <= pending_d;
        end
    end

    assign addr    = addr_q;
    assign pending = pending_q;

endmodule

// File: rtl/sdram_req_gen.sv
// Raises single-burst write/read requests to the SDRAM controller from FIFO fill levels,
// tracking independent wrapping write and read addresses.
module sdram_req_gen
    import sdram_req_gen_pkg::*;
#(
    parameter int unsigned ADDR_W        = SDRAM_ADDR_W,
    parameter int unsigned BURST_W       = SDRAM_BURST_W,
    parameter int unsigned LVL_W         = 11,
    parameter int unsigned RD_FIFO_DEPTH = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sdram_init_done,
    input  logic [LVL_W-1:0]   wr_fifo_level,
    input  logic [LVL_W-1:0]   rd_fifo_level,
    input  logic [ADDR_W-1:0]  wr_min_addr,
    input  logic [ADDR_W-1:0]  wr_max_addr,
    input  logic [ADDR_W-1:0]  rd_min_addr,
    input  logic [ADDR_W-1:0]  rd_max_addr,
    input  logic [BURST_W-1:0] wr_burst_len,
    input  logic [BURST_W-1:0] rd_burst_len,
    input  logic               wr_load,
    input  logic               rd_load,
    input  logic               read_valid,
    input  logic               sdram_wr_ack,
    input  logic               sdram_rd_ack,
    output logic               sdram_wr_req,
    output logic               sdram_rd_req,
    output logic [ADDR_W-1:0]  sdram_wr_addr,
    output logic [ADDR_W-1:0]  sdram_rd_addr,
    output logic [BURST_W-1:0] sdram_wr_burst,
    output logic [BURST_W-1:0] sdram_rd_burst,
    output logic               busy
);

    req_state_t         state_q, state_d;
    logic               wr_req_q, wr_req_d;
    logic               rd_req_q, rd_req_d;
    logic [BURST_W-1:0] wr_burst_q, wr_burst_d;
    logic [BURST_W-1:0] rd_burst_q, rd_burst_d;
    logic               wr_ack_q, rd_ack_q;

    logic wr_pending, rd_pending;
    logic idle, load_cycle;
    logic wr_apply, rd_apply;
    logic wr_fall, rd_fall;
    logic wr_adv, rd_adv;
    logic wr_ok, rd_ok;

    always_comb begin
        idle       = state_q == R_IDLE;
        // Pending restarts take a whole IDLE cycle of their own.
        load_cycle = idle && sdram_init_done && (wr_pending || rd_pending);
        wr_apply   = load_cycle && wr_pending;
        rd_apply   = load_cycle && rd_pending;
        wr_fall    = wr_ack_q && !sdram_wr_ack;
        rd_fall    = rd_ack_q && !sdram_rd_ack;
        wr_adv     = (state_q == R_WR_RUN) && wr_fall;
        rd_adv     = (state_q == R_RD_RUN) && rd_fall;
        wr_ok      = 32'(wr_fifo_level) >= 32'(wr_burst_len);
        rd_ok      = read_valid &&
                     (32'(rd_fifo_level) + 32'(rd_burst_len) <= RD_FIFO_DEPTH);
    end

    always_comb begin
        state_d    = state_q;
        wr_req_d   = wr_req_q;
        rd_req_d   = rd_req_q;
        wr_burst_d = wr_burst_q;
        rd_burst_d = rd_burst_q;
        case (state_q)
            R_IDLE: begin
                if (sdram_init_done && !load_cycle) begin
                    if (wr_ok) begin
                        wr_burst_d = wr_burst_len;
                        wr_req_d   = 1'b1;
                        state_d    = R_WR_REQ;
                    end else if (rd_ok) begin
                        rd_burst_d = rd_burst_len;
                        rd_req_d   = 1'b1;
                        state_d    = R_RD_REQ;
                    end
                end
            end
            R_WR_REQ: begin
                if (sdram_wr_ack) begin
                    wr_req_d = 1'b0;
                    state_d  = R_WR_RUN;
                end
            end
            R_WR_RUN: begin
                if (wr_fall) begin
                    state_d = R_IDLE;
                end
            end
            R_RD_REQ: begin
                if (sdram_rd_ack) begin
                    rd_req_d = 1'b0;
                    state_d  = R_RD_RUN;
                end
            end
            R_RD_RUN: begin
                if (rd_fall) begin
                    state_d = R_IDLE;
                end
            end
            default: begin
                state_d  = R_IDLE;
                wr_req_d = 1'b0;
                rd_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= R_IDLE;
            wr_req_q   <= 1'b0;
            rd_req_q   <= 1'b0;
            wr_burst_q <= '0;
            rd_burst_q <= '0;
            wr_ack_q   <= 1'b0;
            rd_ack_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_req_q   <= wr_req_d;
            rd_req_q   <= rd_req_d;
            wr_burst_q <= wr_burst_d;
            rd_burst_q <= rd_burst_d;
            wr_ack_q   <= sdram_wr_ack;
            rd_ack_q   <= sdram_rd_ack;
        end
    end

    addr_wrap_ctr #(
        .ADDR_W  (ADDR_W),
        .BURST_W (BURST_W)
    ) u_wr_addr (
        .clk        (clk),
        .rst        (rst),
        .load       (wr_load),
        .apply_load (wr_apply),
        .advance    (wr_adv),
        .min_addr   (wr_min_addr),
        .max_addr   (wr_max_addr),
        .burst      (wr_burst_q),
        .addr       (sdram_wr_addr),
        .pending    (wr_pending)
    );

    addr_wrap_ctr #(
        .ADDR_W  (ADDR_W),
        .BURST_W (BURST_W)
    ) u_rd_addr (
        .clk        (clk),
        .rst        (rst),
        .load       (rd_load),
        .apply_load (rd_apply),
        .advance    (rd_adv),
        .min_addr   (rd_min_addr),
        .max_addr   (rd_max_addr),
        .burst      (rd_burst_q),
        .addr       (sdram_rd_addr),
        .pending    (rd_pending)
    );

    assign sdram_wr_req   = wr_req_q;
    assign sdram_rd_req   = rd_req_q;
    assign sdram_wr_burst = wr_burst_q;
    assign sdram_rd_burst = rd_burst_q;
    assign busy           = !idle;

endmodule

// File: tb/tb_sdram_req_gen.sv
// Directed bench for sdram_req_gen: a table of single bursts plus hand-written corner sequences.
module tb_sdram_req_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sdram_init_done = 1'b0;
    logic [10:0] wr_fifo_level = '0;
    logic [10:0] rd_fifo_level = '0;
    logic [23:0] wr_min_addr = '0;
    logic [23:0] wr_max_addr = '0;
    logic [23:0] rd_min_addr = '0;
    logic [23:0] rd_max_addr = '0;
    logic [9:0]  wr_burst_len = '0;
    logic [9:0]  rd_burst_len = '0;
    logic        wr_load = 1'b0;
    logic        rd_load = 1'b0;
    logic        read_valid = 1'b0;
    logic        sdram_wr_ack = 1'b0;
    logic        sdram_rd_ack = 1'b0;
    logic        sdram_wr_req;
    logic        sdram_rd_req;
    logic [23:0] sdram_wr_addr;
    logic [23:0] sdram_rd_addr;
    logic [9:0]  sdram_wr_burst;
    logic [9:0]  sdram_rd_burst;
    logic        busy;

    sdram_req_gen #(
        .ADDR_W        (24),
        .BURST_W       (10),
        .LVL_W         (11),
        .RD_FIFO_DEPTH (1024)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .sdram_init_done (sdram_init_done),
        .wr_fifo_level   (wr_fifo_level),
        .rd_fifo_level   (rd_fifo_level),
        .wr_min_addr     (wr_min_addr),
        .wr_max_addr     (wr_max_addr),
        .rd_min_addr     (rd_min_addr),
        .rd_max_addr     (rd_max_addr),
        .wr_burst_len    (wr_burst_len),
        .rd_burst_len    (rd_burst_len),
        .wr_load         (wr_load),
        .rd_load         (rd_load),
        .read_valid      (read_valid),
        .sdram_wr_ack    (sdram_wr_ack),
        .sdram_rd_ack    (sdram_rd_ack),
        .sdram_wr_req    (sdram_wr_req),
        .sdram_rd_req    (sdram_rd_req),
        .sdram_wr_addr   (sdram_wr_addr),
        .sdram_rd_addr   (sdram_rd_addr),
        .sdram_wr_burst  (sdram_wr_burst),
        .sdram_rd_burst  (sdram_rd_burst),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_rd;
        bit          load;
        logic [23:0] min_a;
        logic [23:0] max_a;
        logic [9:0]  burst;
        logic [23:0] exp_addr;
        logic [23:0] exp_next;
        int          ack_len;
    } vec_t;

    vec_t vecs [13];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(input bit is_rd, input bit load, input logic [23:0] min_a,
                                input logic [23:0] max_a, input logic [9:0] burst,
                                input logic [23:0] exp_addr, input logic [23:0] exp_next,
                                input int ack_len);
        vec_t v;
        v.is_rd    = is_rd;
        v.load     = load;
        v.min_a    = min_a;
        v.max_a    = max_a;
        v.burst    = burst;
        v.exp_addr = exp_addr;
        v.exp_next = exp_next;
        v.ack_len  = ack_len;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_req(input bit is_rd, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if ((is_rd ? sdram_rd_req : sdram_wr_req) === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL %s: got=timeout expected=request within 64 cycles",
                     is_rd ? "rd_req" : "wr_req");
        end
    endtask

    // Plays the controller: acks for ack_len cycles, then drops ack and idles the traffic.
    task automatic run_burst(input bit is_rd, input logic [23:0] exp_addr,
                             input logic [9:0] exp_burst, input logic [23:0] exp_next,
                             input int ack_len, input bit load_mid);
        bit ok;
        wait_req(is_rd, ok);
        if (!ok) return;
        if (is_rd) begin
            check("rd_addr at req", 32'(sdram_rd_addr), 32'(exp_addr));
            check("rd_burst at req", 32'(sdram_rd_burst), 32'(exp_burst));
            check("no wr_req during rd", 32'(sdram_wr_req), 32'd0);
            sdram_rd_ack = 1'b1;
        end else begin
            check("wr_addr at req", 32'(sdram_wr_addr), 32'(exp_addr));
            check("wr_burst at req", 32'(sdram_wr_burst), 32'(exp_burst));
            check("no rd_req during wr", 32'(sdram_rd_req), 32'd0);
            sdram_wr_ack = 1'b1;
        end
        tick(1);
        check("req drops on first ack", 32'(is_rd ? sdram_rd_req : sdram_wr_req), 32'd0);
        check("busy during run", 32'(busy), 32'd1);
        for (int i = 1; i < ack_len; i++) begin
            if (load_mid && i == 1) begin
                if (is_rd) rd_load = 1'b1;
                else       wr_load = 1'b1;
            end
            tick(1);
            wr_load = 1'b0;
            rd_load = 1'b0;
        end
        check("addr stable in run", 32'(is_rd ? sdram_rd_addr : sdram_wr_addr), 32'(exp_addr));
        sdram_wr_ack  = 1'b0;
        sdram_rd_ack  = 1'b0;
        wr_fifo_level = '0;
        read_valid    = 1'b0;
        tick(1);
        check("busy after ack fall", 32'(busy), 32'd0);
        check("addr advanced", 32'(is_rd ? sdram_rd_addr : sdram_wr_addr), 32'(exp_next));
    endtask

    initial begin
        bit ok;

        vecs[0]  = mk(1'b0, 1'b1, 24'h0, 24'hFFFFFF, 10'd256, 24'd0,   24'd256, 256);
        vecs[1]  = mk(1'b0, 1'b1, 24'h0, 24'd1023,   10'd256, 24'd0,   24'd256, 3);
        vecs[2]  = mk(1'b0, 1'b0, 24'h0, 24'd1023,   10'd256, 24'd256, 24'd512, 3);
        vecs[3]  = mk(1'b0, 1'b0, 24'h0, 24'd1023,   10'd256, 24'd512, 24'd768, 3);
        vecs[4]  = mk(1'b0, 1'b0, 24'h0, 24'd1023,   10'd256, 24'd768, 24'd0,   3);
        vecs[5]  = mk(1'b0, 1'b0, 24'h0, 24'd1023,   10'd256, 24'd0,   24'd256, 3);
        vecs[6]  = mk(1'b0, 1'b1, 24'h0, 24'd1000,   10'd256, 24'd0,   24'd256, 2);
        vecs[7]  = mk(1'b0, 1'b0, 24'h0, 24'd1000,   10'd256, 24'd256, 24'd512, 2);
        vecs[8]  = mk(1'b0, 1'b0, 24'h0, 24'd1000,   10'd256, 24'd512, 24'd0,   2);
        vecs[9]  = mk(1'b1, 1'b1, 24'h2000, 24'h2FFF, 10'd128, 24'h2000, 24'h2080, 4);
        vecs[10] = mk(1'b1, 1'b0, 24'h2000, 24'h2FFF, 10'd128, 24'h2080, 24'h2100, 1);
        vecs[11] = mk(1'b1, 1'b0, 24'h2000, 24'h21FF, 10'd128, 24'h2100, 24'h2180, 4);
        vecs[12] = mk(1'b1, 1'b0, 24'h2000, 24'h21FF, 10'd128, 24'h2180, 24'h2000, 4);

        // Reset values
        wr_min_addr   = 24'h40;
        wr_max_addr   = 24'hFFFFFF;
        wr_burst_len  = 10'd256;
        wr_fifo_level = 11'd600;
        rd_min_addr   = 24'h2000;
        rd_max_addr   = 24'h2FFF;
        rd_burst_len  = 10'd128;
        tick(3);
        check("reset wr_req", 32'(sdram_wr_req), 32'd0);
        check("reset rd_req", 32'(sdram_rd_req), 32'd0);
        check("reset wr_addr", 32'(sdram_wr_addr), 32'd0);
        check("reset rd_burst", 32'(sdram_rd_burst), 32'd0);
        check("reset busy", 32'(busy), 32'd0);

        // Init gating, then the load cycle, then the first write request
        rst = 1'b0;
        tick(5);
        check("gated wr_req", 32'(sdram_wr_req), 32'd0);
        check("gated wr_addr", 32'(sdram_wr_addr), 32'd0);
        sdram_init_done = 1'b1;
        tick(1);
        check("load cycle wr_req", 32'(sdram_wr_req), 32'd0);
        check("load cycle wr_addr", 32'(sdram_wr_addr), 32'h40);
        check("load cycle rd_addr", 32'(sdram_rd_addr), 32'h2000);
        tick(1);
        check("wr_req after load", 32'(sdram_wr_req), 32'd1);
        run_burst(1'b0, 24'h40, 10'd256, 24'h140, 4, 1'b0);

        // Table of single bursts: plain, wrapping windows, read path
        for (int k = 0; k < 13; k++) begin
            if (vecs[k].is_rd) begin
                rd_min_addr  = vecs[k].min_a;
                rd_max_addr  = vecs[k].max_a;
                rd_burst_len = vecs[k].burst;
            end else begin
                wr_min_addr  = vecs[k].min_a;
                wr_max_addr  = vecs[k].max_a;
                wr_burst_len = vecs[k].burst;
            end
            if (vecs[k].load) begin
                if (vecs[k].is_rd) rd_load = 1'b1;
                else               wr_load = 1'b1;
                tick(1);
                wr_load = 1'b0;
                rd_load = 1'b0;
                tick(1);
            end
            if (vecs[k].is_rd) begin
                rd_fifo_level = '0;
                read_valid    = 1'b1;
            end else begin
                wr_fifo_level = 11'd600;
            end
            run_burst(vecs[k].is_rd, vecs[k].exp_addr, vecs[k].burst, vecs[k].exp_next,
                      vecs[k].ack_len, 1'b0);
        end

        // Write wins when both are eligible
        rd_fifo_level = '0;
        read_valid    = 1'b1;
        wr_fifo_level = 11'd600;
        wr_max_addr   = 24'd1023;
        wait_req(1'b0, ok);
        check("priority rd_req low", 32'(sdram_rd_req), 32'd0);
        run_burst(1'b0, 24'd0, 10'd256, 24'd256, 3, 1'b0);

        // Read gated by FIFO headroom
        rd_max_addr   = 24'h2FFF;
        rd_burst_len  = 10'd256;
        rd_fifo_level = 11'd800;
        read_valid    = 1'b1;
        tick(10);
        check("no rd_req at level 800", 32'(sdram_rd_req), 32'd0);
        check("idle at level 800", 32'(busy), 32'd0);

        // Read at exact headroom, with a load pulse during RD_RUN
        rd_fifo_level = 11'd768;
        run_burst(1'b1, 24'h2000, 10'd256, 24'h2100, 5, 1'b1);
        tick(1);
        check("mid-burst load applied", 32'(sdram_rd_addr), 32'h2000);
        check("load cycle not busy", 32'(busy), 32'd0);

        // Asynchronous reset while a write request is pending
        wr_min_addr   = 24'h80;
        wr_fifo_level = 11'd600;
        wait_req(1'b0, ok);
        #3;
        rst = 1'b1;
        #1;
        check("async rst wr_req", 32'(sdram_wr_req), 32'd0);
        check("async rst busy", 32'(busy), 32'd0);
        check("async rst wr_addr", 32'(sdram_wr_addr), 32'd0);
        check("async rst wr_burst", 32'(sdram_wr_burst), 32'd0);
        @(posedge clk);
        #1;
        rst           = 1'b0;
        wr_fifo_level = '0;
        tick(1);
        check("restart wr_addr", 32'(sdram_wr_addr), 32'h80);
        check("restart rd_addr", 32'(sdram_rd_addr), 32'h2000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
